// File: rtl/div_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// div_issue_ctrl_if : EXE-side operation, MEM-side result and divider signals
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface div_issue_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_src1;
  logic [31:0]      in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic             div_en;
  logic             div_sign;
  logic [31:0]      div_dividend;
  logic [31:0]      div_divisor;
  logic [63:0]      div_result;
  logic             div_flag;

  modport master (
    input  in_valid, in_op, in_src1, in_src2, in_tag, flush, out_ready,
           div_result, div_flag,
    output in_ready, out_valid, out_data, out_tag, busy,
           div_en, div_sign, div_dividend, div_divisor
  );

  modport slave (
    output in_valid, in_op, in_src1, in_src2, in_tag, flush, out_ready,
           div_result, div_flag,
    input  in_ready, out_valid, out_data, out_tag, busy,
           div_en, div_sign, div_dividend, div_divisor
  );
endinterface

`default_nettype wire

// File: rtl/div_issue_ctrl.sv
// ----------------------------------------------------------------------------
// div_issue_ctrl : issues one DIV/MOD to the multi-cycle divider, returns result
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_issue_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  div_issue_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic             r_mod;
  logic             r_sign;
  logic [31:0]      r_dividend;
  logic [31:0]      r_divisor;
  logic [31:0]      r_out_data;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_out_tag;
  logic             w_accept;

  assign w_accept = (r_state == ST_IDLE) && bus.in_valid && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_mod      <= 1'b0;
      r_sign     <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_out_data <= '0;
      r_tag      <= '0;
      r_out_tag  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dividend <= bus.in_src1;
            r_divisor  <= bus.in_src2;
            r_sign     <= ~bus.in_op[1];
            r_mod      <= bus.in_op[0];
            r_tag      <= bus.in_tag;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.div_flag) begin
            if (bus.flush) begin
              r_state <= ST_IDLE;
            end else begin
              r_out_data <= r_mod ? bus.div_result[63:32] : bus.div_result[31:0];
              r_out_tag  <= r_tag;
              r_state    <= ST_DONE;
            end
          end else if (bus.flush) begin
            r_state <= ST_DRAIN;
          end
        end
        // Keep the divider enabled until it finishes so its counter is not frozen mid-count.
        ST_DRAIN: begin
          if (bus.div_flag) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (bus.flush || bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (r_state == ST_IDLE);
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.out_valid    = (r_state == ST_DONE);
  assign bus.div_en       = (r_state == ST_BUSY) || (r_state == ST_DRAIN);
  assign bus.div_sign     = r_sign;
  assign bus.div_dividend = r_dividend;
  assign bus.div_divisor  = r_divisor;
  assign bus.out_data     = r_out_data;
  assign bus.out_tag      = r_out_tag;

endmodule

`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_div_issue_ctrl : scoreboard bench with a 34-cycle divider model
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_div_issue_ctrl;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_issue_ctrl_if #(.TAG_W(TAG_W)) bus_if ();

  div_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Divider model: counter freezes if enable drops early, rewinds only after finishing.
  logic [5:0]  div_cnt;
  logic [31:0] m_q, m_r;
  always @(posedge clk) begin
    if (reset)                div_cnt <= 6'd0;
    else if (bus_if.div_en)   div_cnt <= (div_cnt == 6'd34) ? 6'd34 : div_cnt + 6'd1;
    else if (div_cnt == 6'd34) div_cnt <= 6'd0;
  end
  assign bus_if.div_flag = bus_if.div_en && (div_cnt == 6'd33);

  always_comb begin
    m_q = 32'd0;
    m_r = 32'd0;
    if (bus_if.div_divisor != 32'd0) begin
      if (bus_if.div_sign) begin
        m_q = $signed(bus_if.div_dividend) / $signed(bus_if.div_divisor);
        m_r = $signed(bus_if.div_dividend) % $signed(bus_if.div_divisor);
      end else begin
        m_q = bus_if.div_dividend / bus_if.div_divisor;
        m_r = bus_if.div_dividend % bus_if.div_divisor;
      end
    end
  end
  assign bus_if.div_result = {m_r, m_q};

  // Scoreboard
  logic [TAG_W+31:0] exp_q[$];
  logic [TAG_W+31:0] e;
  logic [31:0]       cur_exp;
  int                cyc = 0;
  int                acc_cyc = 0;
  logic              prev_ov = 1'b0;
  logic              inflight = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      inflight = 1'b0;
      prev_ov  = 1'b0;
    end else begin
      if (bus_if.out_valid && !inflight) check("valid_without_op", 1, 0);
      if (bus_if.out_valid && !prev_ov) begin
        check("latency", 64'(cyc - acc_cyc), 35);
        check("div_en_low_in_done", bus_if.div_en, 0);
      end
      if (bus_if.out_valid && bus_if.out_ready && !bus_if.flush) begin
        if (exp_q.size() == 0) begin
          check("spurious_transfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus_if.out_data, e[31:0]);
          check("out_tag", bus_if.out_tag, e[TAG_W+31:32]);
        end
        inflight = 1'b0;
      end else if (bus_if.flush && inflight) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        inflight = 1'b0;
      end
      if (bus_if.in_valid && bus_if.in_ready && !bus_if.flush) begin
        exp_q.push_back({bus_if.in_tag, cur_exp});
        acc_cyc  = cyc;
        inflight = 1'b1;
      end
      prev_ov = bus_if.out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp);
    int t = 0;
    while (!bus_if.in_ready && t < 100) begin tick(); t++; end
    check("issue_ready", bus_if.in_ready, 1);
    cur_exp         = exp;
    bus_if.in_valid = 1'b1;
    bus_if.in_op    = op;
    bus_if.in_src1  = a;
    bus_if.in_src2  = b;
    bus_if.in_tag   = tag;
    tick();
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((bus_if.busy || exp_q.size() != 0) && t < 200) begin tick(); t++; end
    check({tag, "_idle_timeout"}, (t < 200), 1);
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (!bus_if.out_valid && t < 100) begin tick(); t++; end
    check({tag, "_valid_timeout"}, bus_if.out_valid, 1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{2'b01, 32'd100,        32'd2 + 32'd5, 32'd2};
    vecs[1] = '{2'b00, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[2] = '{2'b01, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[3] = '{2'b10, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF};
    vecs[4] = '{2'b11, 32'hFFFF_FFFF,  32'd2,         32'd1};

    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_op     = 2'b00;
    bus_if.in_src1   = '0;
    bus_if.in_src2   = '0;
    bus_if.in_tag    = '0;
    bus_if.flush     = 1'b0;
    bus_if.out_ready = 1'b1;
    cur_exp          = '0;
    repeat (3) tick();

    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_div_en", bus_if.div_en, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_in_ready", bus_if.in_ready, 1);
    check("rst_out_data", bus_if.out_data, 0);
    check("rst_out_tag", bus_if.out_tag, 0);
    check("rst_dividend", bus_if.div_dividend, 0);
    check("rst_divisor", bus_if.div_divisor, 0);
    check("rst_div_sign", bus_if.div_sign, 0);
    reset = 1'b0;
    tick();

    // div.w 100/7 with result held back by out_ready
    bus_if.out_ready = 1'b0;
    issue(2'b00, 32'd100, 32'd7, 5'd3, 32'd14);
    check("div_en_after_accept", bus_if.div_en, 1);
    check("in_ready_busy", bus_if.in_ready, 0);
    wait_valid("hold");
    for (int i = 0; i < 5; i++) begin
      check("hold_out_data", bus_if.out_data, 14);
      check("hold_in_ready", bus_if.in_ready, 0);
      check("hold_out_valid", bus_if.out_valid, 1);
      tick();
    end
    bus_if.out_ready = 1'b1;
    wait_idle("hold");

    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 10), vecs[i].exp);
      check("op_div_sign", bus_if.div_sign, {63'd0, ~vecs[i].op[1]});
      check("op_dividend", bus_if.div_dividend, {32'd0, vecs[i].a});
      check("op_divisor", bus_if.div_divisor, {32'd0, vecs[i].b});
      wait_idle("vec");
    end

    // flush at T+10 -> DRAIN until the divider finishes
    issue(2'b00, 32'd1000, 32'd10, 5'd20, 32'd100);
    repeat (9) tick();
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    check("drain_busy", bus_if.busy, 1);
    check("drain_div_en", bus_if.div_en, 1);
    check("drain_in_ready", bus_if.in_ready, 0);
    check("drain_out_valid", bus_if.out_valid, 0);
    begin
      int drops = 0;
      int t = 0;
      while (bus_if.busy && t < 100) begin
        if (!bus_if.div_en) drops++;
        tick();
        t++;
      end
      check("drain_en_held", drops, 0);
      check("drain_timeout", (t < 100), 1);
    end
    issue(2'b00, 32'd9, 32'd3, 5'd21, 32'd3);
    wait_idle("after_drain");

    // flush coincident with div_flag
    issue(2'b01, 32'd50, 32'd6, 5'd22, 32'd2);
    begin
      int t = 0;
      while (!bus_if.div_flag && t < 100) begin tick(); t++; end
      check("flag_seen", bus_if.div_flag, 1);
    end
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    check("flagflush_busy", bus_if.busy, 0);
    check("flagflush_out_valid", bus_if.out_valid, 0);
    check("flagflush_in_ready", bus_if.in_ready, 1);

    // flush during DONE beats out_ready
    bus_if.out_ready = 1'b0;
    issue(2'b00, 32'd40, 32'd4, 5'd23, 32'd10);
    wait_valid("doneflush");
    bus_if.out_ready = 1'b1;
    bus_if.flush     = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    check("doneflush_out_valid", bus_if.out_valid, 0);
    check("doneflush_busy", bus_if.busy, 0);

    // in_valid together with flush in IDLE is not accepted
    bus_if.in_valid = 1'b1;
    bus_if.in_op    = 2'b00;
    bus_if.in_src1  = 32'd8;
    bus_if.in_src2  = 32'd2;
    bus_if.flush    = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.flush    = 1'b0;
    check("idleflush_busy", bus_if.busy, 0);
    check("idleflush_in_ready", bus_if.in_ready, 1);
    check("idleflush_queue", exp_q.size(), 0);

    // reset mid-BUSY
    issue(2'b00, 32'd77, 32'd7, 5'd24, 32'd11);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("midrst_div_en", bus_if.div_en, 0);
    check("midrst_busy", bus_if.busy, 0);
    check("midrst_in_ready", bus_if.in_ready, 1);
    check("midrst_out_valid", bus_if.out_valid, 0);
    reset = 1'b0;
    tick();
    issue(2'b00, 32'd50, 32'd5, 5'd25, 32'd10);
    wait_idle("after_reset");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
